// File: rtl/qgate_sequencer_pkg.sv
// Shared types and helpers for the Pauli-gate sequencer: amplitude format, gate and FSM encodings.
// FIXED_WIDTH may be overridden on the command line; it defaults to 16 (Q2.14).
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

package quasar_pkg;

  localparam int unsigned FIXED_WIDTH = `FIXED_WIDTH;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  typedef enum logic [1:0] {
    GATE_I = 2'b00,
    GATE_X = 2'b01,
    GATE_Y = 2'b10,
    GATE_Z = 2'b11
  } gate_op_e;

  typedef struct packed {
    fixed_t re;
    fixed_t im;
  } amp_t;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StCapB,
    StWrA,
    StWrB,
    StDone,
    StErr
  } seq_state_e;

  // Two's-complement negation with the most negative value clamped to the most positive.
  function automatic fixed_t sat_neg(fixed_t x);
    if (x == {1'b1, {(FIXED_WIDTH-1){1'b0}}}) begin
      return {1'b0, {(FIXED_WIDTH-1){1'b1}}};
    end
    return -x;
  endfunction

endpackage

// File: rtl/qgate_sequencer_if.sv
// Command and amplitude-RAM bundle for qgate_sequencer; slave is the sequencer's view.
// QGATE_SEQ_PERF_EN adds the gate/pair performance counters to the bundle.
interface qgate_sequencer_if #(
  parameter int unsigned NUM_QUBITS = 4
) ();

  localparam int unsigned TGT_W = $clog2(NUM_QUBITS) + 1;

  logic                                start;
  logic [1:0]                          gate_op;
  logic [TGT_W-1:0]                    target;
  logic                                busy;
  logic                                done;
  logic                                err;
  logic [NUM_QUBITS-1:0]               mem_addr;
  logic                                mem_rd_en;
  logic [quasar_pkg::FIXED_WIDTH-1:0]  mem_rdata_re;
  logic [quasar_pkg::FIXED_WIDTH-1:0]  mem_rdata_im;
  logic                                mem_wr_en;
  logic [quasar_pkg::FIXED_WIDTH-1:0]  mem_wdata_re;
  logic [quasar_pkg::FIXED_WIDTH-1:0]  mem_wdata_im;
`ifdef QGATE_SEQ_PERF_EN
  logic [31:0]                         gate_count;
  logic [31:0]                         pair_count;

  modport slave (
    input  start, gate_op, target, mem_rdata_re, mem_rdata_im,
    output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata_re, mem_wdata_im,
    output gate_count, pair_count
  );
  modport master (
    output start, gate_op, target, mem_rdata_re, mem_rdata_im,
    input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata_re, mem_wdata_im,
    input  gate_count, pair_count
  );
`else
  modport slave (
    input  start, gate_op, target, mem_rdata_re, mem_rdata_im,
    output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata_re, mem_wdata_im
  );
  modport master (
    output start, gate_op, target, mem_rdata_re, mem_rdata_im,
    input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata_re, mem_wdata_im
  );
`endif

endinterface

// File: rtl/qgate_sequencer_pauli_pair_alu.sv
// Combinational Pauli transform of one amplitude pair (A = target bit 0, B = target bit 1).
module pauli_pair_alu
  import quasar_pkg::*;
(
  input  gate_op_e gate_op_i,
  input  amp_t     a_i,
  input  amp_t     b_i,
  output amp_t     a_o,
  output amp_t     b_o
);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    unique case (gate_op_i)
      GATE_I: ;
      GATE_X: begin
        a_o = b_i;
        b_o = a_i;
      end
      GATE_Y: begin
        a_o.re = b_i.im;
        a_o.im = sat_neg(b_i.re);
        b_o.re = sat_neg(a_i.im);
        b_o.im = a_i.re;
      end
      GATE_Z: begin
        b_o.re = sat_neg(b_i.re);
        b_o.im = sat_neg(b_i.im);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/qgate_sequencer.sv
// Applies one Pauli gate to a target qubit by walking every amplitude pair in external RAM.
// Optional QGATE_SEQ_PERF_EN adds gate_count / pair_count counters.
module qgate_sequencer
  import quasar_pkg::*;
#(
  parameter int unsigned NUM_QUBITS = 4
) (
  input logic         clk,
  input logic         rst_n,
  qgate_sequencer_if.slave bus
);

  localparam int unsigned TGT_W = $clog2(NUM_QUBITS) + 1;
  localparam int unsigned K_W   = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'((2 ** (NUM_QUBITS - 1)) - 1);

  seq_state_e       state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  gate_op_e         op_q, op_d;
  logic [TGT_W-1:0] tgt_q, tgt_d;
  amp_t             a_q, a_d, b_q, b_d;
  amp_t             a_new, b_new;

  logic [NUM_QUBITS-1:0] k_ext, tgt_bit, low_mask, addr_a, addr_b;

  // Insert the target bit into k: bits below the target stay, bits above shift up by one.
  assign k_ext    = NUM_QUBITS'(k_q);
  assign tgt_bit  = NUM_QUBITS'(1) << tgt_q;
  assign low_mask = tgt_bit - NUM_QUBITS'(1);
  assign addr_a   = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
  assign addr_b   = addr_a | tgt_bit;

  pauli_pair_alu u_alu (
    .gate_op_i (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .a_o       (a_new),
    .b_o       (b_new)
  );

  logic                  busy, done, err, rd_en, wr_en;
  logic [NUM_QUBITS-1:0] addr;
  amp_t                  wdata;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = gate_op_e'(bus.gate_op);
          tgt_d = bus.target;
          k_d   = '0;
          if (bus.target >= TGT_W'(NUM_QUBITS)) begin
            state_d = StErr;
          end else if (gate_op_e'(bus.gate_op) == GATE_I) begin
            state_d = StDone;
          end else begin
            state_d = StRdA;
          end
        end
      end
      StRdA: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        addr    = addr_a;
        state_d = StRdB;
      end
      StRdB: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        addr    = addr_b;
        a_d     = '{re: bus.mem_rdata_re, im: bus.mem_rdata_im};
        state_d = StCapB;
      end
      StCapB: begin
        busy    = 1'b1;
        b_d     = '{re: bus.mem_rdata_re, im: bus.mem_rdata_im};
        state_d = StWrA;
      end
      StWrA: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        addr    = addr_a;
        wdata   = a_new;
        state_d = StWrB;
      end
      StWrB: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        addr  = addr_b;
        wdata = b_new;
        if (k_q == K_LAST) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = StRdA;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      StErr: begin
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      op_q    <= GATE_I;
      tgt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_wr_en    = wr_en;
  assign bus.mem_addr     = addr;
  assign bus.mem_wdata_re = wdata.re;
  assign bus.mem_wdata_im = wdata.im;

`ifdef QGATE_SEQ_PERF_EN
  logic [31:0] gate_count_q, pair_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_count_q <= '0;
      pair_count_q <= '0;
    end else begin
      if (state_q == StDone) gate_count_q <= gate_count_q + 32'd1;
      if (state_q == StWrB)  pair_count_q <= pair_count_q + 32'd1;
    end
  end

  assign bus.gate_count = gate_count_q;
  assign bus.pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_qgate_sequencer.sv
// Scoreboard bench for qgate_sequencer (NUM_QUBITS=2): expected RAM/done/err events are queued by
// the stimulus and popped by a monitor whenever the DUT presents one.
module tb_qgate_sequencer;
  import quasar_pkg::*;

  localparam int unsigned NQ = 2;
  localparam int unsigned TW = $clog2(NQ) + 1;

  localparam logic [1:0] KRd = 2'd0, KWr = 2'd1, KDone = 2'd2, KErr = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [NQ-1:0] addr;
    logic [15:0]   re;
    logic [15:0]   im;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qgate_sequencer_if #(.NUM_QUBITS(NQ)) bus ();

  qgate_sequencer #(.NUM_QUBITS(NQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  logic [15:0] mem_re [0:(1<<NQ)-1];
  logic [15:0] mem_im [0:(1<<NQ)-1];

  // Amplitude RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata_re <= mem_re[bus.mem_addr];
      bus.mem_rdata_im <= mem_im[bus.mem_addr];
    end
    if (bus.mem_wr_en) begin
      mem_re[bus.mem_addr] = bus.mem_wdata_re;
      mem_im[bus.mem_addr] = bus.mem_wdata_im;
    end
  end

  // Monitor: every presented event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (bus.mem_rd_en || bus.mem_wr_en || bus.done || bus.err)) begin
      ev_t act;
      ev_t exp;
      act = '0;
      if (bus.mem_wr_en) begin
        act.kind = KWr;
        act.addr = bus.mem_addr;
        act.re   = bus.mem_wdata_re;
        act.im   = bus.mem_wdata_im;
      end else if (bus.mem_rd_en) begin
        act.kind = KRd;
        act.addr = bus.mem_addr;
      end else if (bus.done) begin
        act.kind = KDone;
      end else begin
        act.kind = KErr;
      end
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard: unexpected event kind=%0d addr=%0d data=%h_%h at %0t",
                 act.kind, act.addr, act.re, act.im, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors = errors + 1;
          $display("FAIL scoreboard: got kind=%0d addr=%0d data=%h_%h, expected kind=%0d addr=%0d data=%h_%h",
                   act.kind, act.addr, act.re, act.im, exp.kind, exp.addr, exp.re, exp.im);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int a, input logic [15:0] re,
                      input logic [15:0] im);
    ev_t e;
    e.kind = kind;
    e.addr = NQ'(a);
    e.re   = re;
    e.im   = im;
    exp_q.push_back(e);
  endtask

  task automatic load(input int a, input logic [15:0] re, input logic [15:0] im);
    mem_re[a] = re;
    mem_im[a] = im;
  endtask

  task automatic chk_mem(input int a, input logic [15:0] re, input logic [15:0] im);
    chk($sformatf("mem[%0d]", a), {mem_re[a], mem_im[a]}, {re, im});
  endtask

  // Issue one command and measure start-to-done/err latency; optionally poke start while busy
  // (at cycle inject_at) and during the done/err cycle.
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [TW-1:0] tgt,
                         input int exp_lat, input logic exp_busy, input int inject_at,
                         input bit inject_done);
    int cnt;
    bit seen;
    bus.gate_op = op;
    bus.target  = tgt;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cnt  = 1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cnt == 1) chk({nm, " busy"}, 32'(bus.busy), 32'(exp_busy));
      if (bus.done || bus.err) begin
        seen = 1'b1;
        break;
      end
      if (cnt == inject_at) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cnt++;
    end
    if (seen) begin
      chk({nm, " latency"}, 32'(cnt), 32'(exp_lat));
    end else begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s timeout: no done/err within 200 cycles, expected latency %0d", nm, exp_lat);
    end
    if (inject_done) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk({nm, " idle busy after done"}, 32'(bus.busy), 32'd0);
      chk({nm, " idle rd_en after done"}, 32'(bus.mem_rd_en), 32'd0);
    end
    repeat (4) @(posedge clk);
    #1 chk({nm, " queue drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.gate_op = 2'b00;
    bus.target  = '0;
    for (int i = 0; i < (1 << NQ); i++) load(i, 16'h0, 16'h0);

    #23;
    chk("reset busy",  32'(bus.busy), 32'd0);
    chk("reset done",  32'(bus.done), 32'd0);
    chk("reset err",   32'(bus.err), 32'd0);
    chk("reset rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("reset wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("reset addr",  32'(bus.mem_addr), 32'd0);
    chk("reset wdata", {bus.mem_wdata_re, bus.mem_wdata_im}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Y on target 0
    load(0, 16'h4000, 16'h0000); load(1, 16'h0, 16'h0); load(2, 16'h0, 16'h0);
    load(3, 16'h0, 16'h0);
    push(KRd, 0, 0, 0); push(KRd, 1, 0, 0);
    push(KWr, 0, 16'h0000, 16'h0000); push(KWr, 1, 16'h0000, 16'h4000);
    push(KRd, 2, 0, 0); push(KRd, 3, 0, 0);
    push(KWr, 2, 16'h0000, 16'h0000); push(KWr, 3, 16'h0000, 16'h0000);
    push(KDone, 0, 0, 0);
    run_cmd("Y t0", 2'b10, 2'd0, 11, 1'b1, -1, 1'b0);
    chk_mem(0, 16'h0000, 16'h0000);
    chk_mem(1, 16'h0000, 16'h4000);

    // X on target 1: address trace 0,2,0,2,1,3,1,3
    for (int i = 0; i < 4; i++) load(i, 16'(i), 16'(-i));
    push(KRd, 0, 0, 0); push(KRd, 2, 0, 0);
    push(KWr, 0, 16'h0002, 16'hFFFE); push(KWr, 2, 16'h0000, 16'h0000);
    push(KRd, 1, 0, 0); push(KRd, 3, 0, 0);
    push(KWr, 1, 16'h0003, 16'hFFFD); push(KWr, 3, 16'h0001, 16'hFFFF);
    push(KDone, 0, 0, 0);
    run_cmd("X t1", 2'b01, 2'd1, 11, 1'b1, -1, 1'b0);
    chk_mem(0, 16'h0002, 16'hFFFE);
    chk_mem(1, 16'h0003, 16'hFFFD);
    chk_mem(2, 16'h0000, 16'h0000);
    chk_mem(3, 16'h0001, 16'hFFFF);

    // Z on target 0 with saturating negation
    load(0, 16'h0001, 16'h0002); load(1, 16'h8000, 16'h7FFF);
    load(2, 16'h0003, 16'h0004); load(3, 16'hFFFB, 16'h0000);
    push(KRd, 0, 0, 0); push(KRd, 1, 0, 0);
    push(KWr, 0, 16'h0001, 16'h0002); push(KWr, 1, 16'h7FFF, 16'h8001);
    push(KRd, 2, 0, 0); push(KRd, 3, 0, 0);
    push(KWr, 2, 16'h0003, 16'h0004); push(KWr, 3, 16'h0005, 16'h0000);
    push(KDone, 0, 0, 0);
    run_cmd("Z t0", 2'b11, 2'd0, 11, 1'b1, -1, 1'b0);
    chk_mem(1, 16'h7FFF, 16'h8001);
    chk_mem(3, 16'h0005, 16'h0000);

    // Out-of-range targets
    push(KErr, 0, 0, 0);
    run_cmd("err t2", 2'b01, 2'd2, 1, 1'b0, -1, 1'b0);
    push(KErr, 0, 0, 0);
    run_cmd("err t3", 2'b10, 2'd3, 1, 1'b0, -1, 1'b0);

    // Identity: no RAM traffic
    push(KDone, 0, 0, 0);
    run_cmd("I t1", 2'b00, 2'd1, 1, 1'b1, -1, 1'b0);

    // X on target 0 with start pokes while busy and during done
    push(KRd, 0, 0, 0); push(KRd, 1, 0, 0);
    push(KWr, 0, 16'h7FFF, 16'h8001); push(KWr, 1, 16'h0001, 16'h0002);
    push(KRd, 2, 0, 0); push(KRd, 3, 0, 0);
    push(KWr, 2, 16'h0005, 16'h0000); push(KWr, 3, 16'h0003, 16'h0004);
    push(KDone, 0, 0, 0);
    run_cmd("X t0 poke", 2'b01, 2'd0, 11, 1'b1, 3, 1'b1);
    chk_mem(0, 16'h7FFF, 16'h8001);
    chk_mem(3, 16'h0003, 16'h0004);

    // Reset during WR_A of a Y command
    load(0, 16'h4000, 16'h0000); load(1, 16'h0000, 16'hC000);
    load(2, 16'h0000, 16'h0000); load(3, 16'h0100, 16'h0200);
    push(KRd, 0, 0, 0); push(KRd, 1, 0, 0);
    bus.gate_op = 2'b10;
    bus.target  = 2'd0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst busy",  32'(bus.busy), 32'd0);
    chk("midrst rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("midrst wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("midrst addr",  32'(bus.mem_addr), 32'd0);
    chk("midrst wdata", {bus.mem_wdata_re, bus.mem_wdata_im}, 32'd0);
    chk("midrst queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh Y on target 1 after reset
    push(KRd, 0, 0, 0); push(KRd, 2, 0, 0);
    push(KWr, 0, 16'h0000, 16'h0000); push(KWr, 2, 16'h0000, 16'h4000);
    push(KRd, 1, 0, 0); push(KRd, 3, 0, 0);
    push(KWr, 1, 16'h0200, 16'hFF00); push(KWr, 3, 16'h4000, 16'h0000);
    push(KDone, 0, 0, 0);
    run_cmd("Y t1 after rst", 2'b10, 2'd1, 11, 1'b1, -1, 1'b0);
    chk_mem(1, 16'h0200, 16'hFF00);
    chk_mem(2, 16'h0000, 16'h4000);
    chk_mem(3, 16'h4000, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
